// File: rtl/wb_write_sequencer.sv
// Writeback sequencer: queues retiring results and issues one register-file write per cycle.
// Optional WB_BYPASS_EN adds a combinational forwarding search over pending writes.
module wb_write_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_regwrite,
    input  logic [AW-1:0]   in_rd,
    input  logic [1:0]      in_sel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_mem,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [XLEN-1:0] in_imm,
    input  logic            dbg_req,
    input  logic [AW-1:0]   dbg_add,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_ack,
    output logic            RegWrite,
    output logic [AW-1:0]   w_add,
    output logic [XLEN-1:0] RegWriteData,
    output logic [31:0]     retire_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]   byp_rs1,
    input  logic [AW-1:0]   byp_rs2,
    output logic            byp_hit1,
    output logic            byp_hit2,
    output logic [XLEN-1:0] byp_data1,
    output logic [XLEN-1:0] byp_data2
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]   rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q, ack_q, we_q;
    logic [AW-1:0]   wadd_q;
    logic [XLEN-1:0] wdata_q;
    logic [31:0]     retire_q;

    logic            xfer, push, pop, full, empty, dbg_go, dbg_wr;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        sel_data = in_alu;
        case (in_sel)
            2'b00:   sel_data = in_alu;
            2'b01:   sel_data = in_mem;
            2'b10:   sel_data = in_pc4;
            default: sel_data = in_imm;
        endcase
    end

    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        xfer  = in_valid & ready_q;
        push  = xfer & in_regwrite & (in_rd != '0);
        // ack_q blocks a second issue while the requester is still seeing its ack.
        // A full queue blocks debug so the queue always gets the slot.
        dbg_go  = dbg_req & ~ack_q & ~full;
        dbg_wr  = dbg_go & (dbg_add != '0);
        pop     = ~dbg_wr & ~empty;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            we_q     <= 1'b0;
            wadd_q   <= '0;
            wdata_q  <= '0;
            retire_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
            ack_q   <= dbg_go;
            we_q    <= dbg_wr | pop;
            if (xfer) begin
                retire_q <= retire_q + 32'd1;
            end
            if (push) begin
                rd_mem[tail_q]   <= in_rd;
                data_mem[tail_q] <= sel_data;
                tail_q           <= tail_q + PW'(1);
            end
            if (dbg_wr) begin
                wadd_q  <= dbg_add;
                wdata_q <= dbg_data;
            end else if (pop) begin
                wadd_q  <= rd_mem[head_q];
                wdata_q <= data_mem[head_q];
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
        end
    end

    assign in_ready     = ready_q;
    assign dbg_ack      = ack_q;
    assign RegWrite     = we_q;
    assign w_add        = wadd_q;
    assign RegWriteData = wdata_q;
    assign retire_count = retire_q;

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        idx       = '0;
        if (we_q && wadd_q == byp_rs1) begin
            byp_hit1  = 1'b1;
            byp_data1 = wdata_q;
        end
        if (we_q && wadd_q == byp_rs2) begin
            byp_hit2  = 1'b1;
            byp_data2 = wdata_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (rd_mem[idx] == byp_rs1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_mem[idx];
                end
                if (rd_mem[idx] == byp_rs2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_mem[idx];
                end
            end
        end
        if (byp_rs1 == '0) begin
            byp_hit1  = 1'b0;
            byp_data1 = '0;
        end
        if (byp_rs2 == '0) begin
            byp_hit2  = 1'b0;
            byp_data2 = '0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Randomized bench for wb_write_sequencer against a queue-based reference model.
// Bypass checks are compiled in when WB_BYPASS_EN is defined.
module tb_wb_write_sequencer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_regwrite;
    logic [4:0]  in_rd;
    logic [1:0]  in_sel;
    logic [31:0] in_alu, in_mem, in_pc4, in_imm;
    logic        dbg_req, dbg_ack;
    logic [4:0]  dbg_add;
    logic [31:0] dbg_data;
    logic        RegWrite;
    logic [4:0]  w_add;
    logic [31:0] RegWriteData;
    logic [31:0] retire_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs1, byp_rs2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    wb_write_sequencer #(.XLEN(32), .AW(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_sel(in_sel),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc4(in_pc4), .in_imm(in_imm),
        .dbg_req(dbg_req), .dbg_add(dbg_add), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .RegWrite(RegWrite), .w_add(w_add), .RegWriteData(RegWriteData),
        .retire_count(retire_count)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];     // pending queued writes, program order
    logic [31:0] wlog[$];   // every observed write value
    int unsigned mretire;
    int          checks, passed, acks;
    logic        last_xfer;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s);
        case (s)
            2'd0:    return in_alu;
            2'd1:    return in_mem;
            2'd2:    return in_pc4;
            default: return in_imm;
        endcase
    endfunction

    // One clock: predict from the model, advance, compare, update the model.
    task automatic tick();
        logic xfer, do_push, dgo, dwr, exp_we;
        wr_t  nw, de, e;
        xfer    = in_valid && in_ready;
        do_push = xfer && in_regwrite && (in_rd != 5'd0);
        nw      = '{a: in_rd, d: pick(in_sel)};
        de      = '{a: dbg_add, d: dbg_data};
        dgo     = dbg_req && !dbg_ack && (wq.size() < DEPTH);
        dwr     = dgo && (dbg_add != 5'd0);
        exp_we  = dwr || (wq.size() > 0);
        @(posedge clk);
        #1;
        check("dbg_ack", dbg_ack, dgo);
        check("regwrite", RegWrite, exp_we);
        if (exp_we) begin
            e = dwr ? de : wq.pop_front();
            check("w_add", w_add, e.a);
            check("wdata", RegWriteData, e.d);
        end
        if (RegWrite) wlog.push_back(RegWriteData);
        if (xfer) mretire++;
        if (do_push) wq.push_back(nw);
        check("retire", retire_count, mretire);
        check("in_ready", in_ready, wq.size() < DEPTH);
        if (dbg_ack) begin
            acks++;
            dbg_req = 1'b0;
        end
        last_xfer = xfer;
    endtask

    task automatic send(input logic [4:0] rd, input logic rw, input logic [1:0] s,
                        input logic [31:0] v);
        int n;
        in_valid = 1'b1; in_regwrite = rw; in_rd = rd; in_sel = s;
        in_alu = 32'hA000_0000 ^ v; in_mem = 32'hB000_0000 ^ v;
        in_pc4 = 32'hC000_0000 ^ v; in_imm = 32'hD000_0000 ^ v;
        case (s)
            2'd0: in_alu = v;
            2'd1: in_mem = v;
            2'd2: in_pc4 = v;
            default: in_imm = v;
        endcase
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_xfer && n < 20);
        if (!last_xfer) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        int sent, wl0, a0;
        logic saw_full;
        checks = 0; passed = 0; acks = 0; mretire = 0;
        rst = 1'b1; in_valid = 0; in_regwrite = 0; in_rd = 0; in_sel = 0;
        in_alu = 0; in_mem = 0; in_pc4 = 0; in_imm = 0;
        dbg_req = 0; dbg_add = 0; dbg_data = 0;
`ifdef WB_BYPASS_EN
        byp_rs1 = 0; byp_rs2 = 0;
`endif
        #12;
        check("rst_ready", in_ready, 0);
        check("rst_we", RegWrite, 0);
        check("rst_wadd", w_add, 0);
        check("rst_wdata", RegWriteData, 0);
        check("rst_ack", dbg_ack, 0);
        check("rst_retire", retire_count, 0);
        @(negedge clk); rst = 1'b0;
        tick();
        check("ready_after_rst", in_ready, 1);

        // Single result: write visible one cycle after the transfer edge.
        send(5'd5, 1'b1, 2'd0, 32'h1234);
        check("t2_no_we_yet", RegWrite, 0);
        tick();
        check("t2_we", RegWrite, 1);
        check("t2_add", w_add, 5);
        check("t2_data", RegWriteData, 32'h1234);
        check("t2_retire", retire_count, 1);

        // x0 and non-writing transfers retire without a write.
        repeat (2) tick();
        wl0 = wlog.size();
        send(5'd0, 1'b1, 2'd0, 32'hFFFF);
        send(5'd7, 1'b0, 2'd0, 32'h5555);
        repeat (3) tick();
        check("t3_nowrites", wlog.size(), wl0);
        check("t3_retire", retire_count, 3);

        // Held debug request plus a stream of four results.
        a0 = acks;
        dbg_req = 1; dbg_add = 5'd3; dbg_data = 32'hAA;
        send(5'd10, 1'b1, 2'd0, 32'h100);
        check("t4_dbg_first_add", w_add, 3);
        check("t4_dbg_first_data", RegWriteData, 32'hAA);
        send(5'd11, 1'b1, 2'd0, 32'h101);
        send(5'd12, 1'b1, 2'd0, 32'h102);
        send(5'd13, 1'b1, 2'd0, 32'h103);
        repeat (4) tick();
        check("t4_one_ack", acks - a0, 1);
        check("t4_drained", wq.size(), 0);

        // Select mux.
        wl0 = wlog.size();
        send(5'd1, 1'b1, 2'd1, 32'hDEAD);
        send(5'd2, 1'b1, 2'd2, 32'h104);
        send(5'd4, 1'b1, 2'd3, 32'h1234_5000);
        repeat (3) tick();
        check("t5_count", wlog.size() - wl0, 3);
        if (wlog.size() - wl0 == 3) begin
            check("t5_mem", wlog[wl0], 32'hDEAD);
            check("t5_pc4", wlog[wl0+1], 32'h104);
            check("t5_imm", wlog[wl0+2], 32'h1234_5000);
        end

`ifdef WB_BYPASS_EN
        byp_rs1 = 5'd9; byp_rs2 = 5'd0;
        send(5'd9, 1'b1, 2'd0, 32'h11);
        send(5'd9, 1'b1, 2'd0, 32'h22);
        check("t6_hit1", byp_hit1, 1);
        check("t6_data1", byp_data1, 32'h22);
        check("t6_hit2", byp_hit2, 0);
        check("t6_data2", byp_data2, 0);
        repeat (3) tick();
`endif

        // Repeated debug requests steal issue slots until the queue fills.
        saw_full = 0; sent = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            if (!in_valid) begin
                in_valid = 1; in_regwrite = 1; in_rd = 5'(20 + sent); in_sel = 0;
                in_alu = 32'h300 + 32'(sent);
            end
            if (!dbg_req) begin
                dbg_req = 1; dbg_add = 5'd30; dbg_data = $urandom;
            end
            tick();
            if (!in_ready) saw_full = 1;
            if (last_xfer) begin
                in_valid = 0;
                sent++;
            end
        end
        check("fill_ready_drop", saw_full, 1);
        check("fill_sent", sent, 8);

        // Asynchronous reset in the middle of a cycle with writes pending.
        in_valid = 1; in_rd = 5'd21; in_alu = 32'h77;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mrst_we", RegWrite, 0);
        check("mrst_retire", retire_count, 0);
        check("mrst_ready", in_ready, 0);
        check("mrst_ack", dbg_ack, 0);
        wq.delete(); mretire = 0; in_valid = 0; dbg_req = 0;
        @(negedge clk); rst = 1'b0;
        wl0 = wlog.size();
        repeat (4) tick();
        check("mrst_ready_after", in_ready, 1);
        check("mrst_nowrites", wlog.size(), wl0);

        // Random traffic with occasional debug writes (including address 0).
        for (int c = 0; c < 400; c++) begin
            if (!in_valid && ($urandom_range(0, 3) != 0)) begin
                in_valid = 1; in_regwrite = ($urandom_range(0, 4) != 0);
                in_rd = 5'($urandom_range(0, 31)); in_sel = 2'($urandom_range(0, 3));
                in_alu = $urandom; in_mem = $urandom; in_pc4 = $urandom; in_imm = $urandom;
            end
            if (!dbg_req && $urandom_range(0, 7) == 0) begin
                dbg_req = 1; dbg_add = 5'($urandom_range(0, 31)); dbg_data = $urandom;
            end
            tick();
            if (last_xfer) in_valid = 0;
        end
        in_valid = 0; dbg_req = 0;
        repeat (5) tick();
        check("final_drained", wq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
